rob_retire: RTL and testbench

- Reorder buffer that sits directly upstream of the architectural register file.
- Allocates entries in program order at dispatch and records results from the writeback ports.
- Commits up to 2 completed instructions per cycle, in order, from the head. The retire lanes are the ARF's write ports.
- On an exception at the head it raises flush and empties itself.

---
 rtl/rob_retire.sv | 123 ++++++++++++
 tb/tb_rob_retire.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rob_retire.sv
// Reorder buffer feeding the architectural register file: in-order dispatch,
// out-of-order writeback, up to two in-order retires per cycle, flush on a
// faulting head entry.
module rob_retire #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned IDXW   = $clog2(DEPTH),
  parameter int unsigned DWIDTH = 32
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [1:0]                   i_disp_valid,
  input  logic [1:0][4:0]              i_disp_dst,
  input  logic [1:0]                   i_disp_regwrite,
  output logic                         o_disp_ready,
  output logic [1:0][IDXW-1:0]         o_disp_idx,
  input  logic [1:0]                   i_wb_valid,
  input  logic [1:0][IDXW-1:0]         i_wb_idx,
  input  logic [1:0][DWIDTH-1:0]       i_wb_data,
  input  logic [1:0]                   i_wb_exc,
  output logic [1:0]                   o_ret_valid,
  output logic [1:0][4:0]              o_ret_dst,
  output logic [1:0]                   o_ret_regwrite,
  output logic [1:0][DWIDTH-1:0]       o_ret_data,
  output logic                         o_flush,
  output logic [IDXW:0]                o_count
);

  localparam int unsigned CW = IDXW + 1;

  logic [IDXW-1:0]   r_head;
  logic [IDXW-1:0]   r_tail;
  logic [IDXW:0]     r_count;
  logic [DEPTH-1:0]  r_alloc;
  logic [DEPTH-1:0]  r_done;
  logic [DEPTH-1:0]  r_exc;
  logic [DEPTH-1:0]  r_rw;
  logic [4:0]        r_dst  [DEPTH];
  logic [DWIDTH-1:0] r_data [DEPTH];

  logic [IDXW-1:0]   w_head1;
  logic              w_r0;
  logic              w_r1;
  logic [1:0]        w_acc;
  logic [1:0]        w_nacc;
  logic [1:0]        w_nret;

  // Retire eligibility, flush detect, dispatch acceptance and slot assignment
  always_comb begin
    w_head1           = r_head + IDXW'(1);
    w_r0              = r_alloc[r_head] & r_done[r_head] & ~r_exc[r_head];
    w_r1              = w_r0 & r_alloc[w_head1] & r_done[w_head1] & ~r_exc[w_head1];
    o_flush           = r_alloc[r_head] & r_done[r_head] & r_exc[r_head];
    o_ret_valid       = {w_r1, w_r0};
    o_ret_dst[0]      = r_dst[r_head];
    o_ret_dst[1]      = r_dst[w_head1];
    o_ret_data[0]     = r_data[r_head];
    o_ret_data[1]     = r_data[w_head1];
    o_ret_regwrite[0] = w_r0 & r_rw[r_head];
    o_ret_regwrite[1] = w_r1 & r_rw[w_head1];
    o_disp_ready      = (r_count <= CW'(DEPTH - 2));
    w_acc             = i_disp_valid & {2{o_disp_ready & ~o_flush}};
    o_disp_idx[0]     = r_tail;
    o_disp_idx[1]     = r_tail + IDXW'(i_disp_valid[0]);
    w_nacc            = {1'b0, w_acc[0]} + {1'b0, w_acc[1]};
    w_nret            = {1'b0, w_r0} + {1'b0, w_r1};
    o_count           = r_count;
  end

  // Pointers, occupancy and per-entry status bits
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_alloc <= '0;
      r_done  <= '0;
      r_exc   <= '0;
    end else if (o_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_alloc <= '0;
      r_done  <= '0;
      r_exc   <= '0;
    end else begin
      r_head  <= r_head + IDXW'(w_nret);
      r_tail  <= r_tail + IDXW'(w_nacc);
      r_count <= r_count + CW'(w_nacc) - CW'(w_nret);
      // Port 1 is applied last so it wins on a shared index
      for (int p = 0; p < 2; p++) begin
        if (i_wb_valid[p] && r_alloc[i_wb_idx[p]]) begin
          r_done[i_wb_idx[p]] <= 1'b1;
          r_exc[i_wb_idx[p]]  <= i_wb_exc[p];
        end
      end
      if (w_r0) r_alloc[r_head]  <= 1'b0;
      if (w_r1) r_alloc[w_head1] <= 1'b0;
      for (int l = 0; l < 2; l++) begin
        if (w_acc[l]) begin
          r_alloc[o_disp_idx[l]] <= 1'b1;
          r_done[o_disp_idx[l]]  <= 1'b0;
          r_exc[o_disp_idx[l]]   <= 1'b0;
        end
      end
    end
  end

  // Payload storage; contents are only meaningful while the entry is allocated
  always_ff @(posedge clk) begin
    for (int l = 0; l < 2; l++) begin
      if (w_acc[l]) begin
        r_dst[o_disp_idx[l]] <= i_disp_dst[l];
        r_rw[o_disp_idx[l]]  <= i_disp_regwrite[l];
      end
    end
    for (int p = 0; p < 2; p++) begin
      if (i_wb_valid[p] && r_alloc[i_wb_idx[p]]) begin
        r_data[i_wb_idx[p]] <= i_wb_data[p];
      end
    end
  end

endmodule

// File: tb/tb_rob_retire.sv
// Bench for rob_retire: directed scenarios followed by random traffic, all
// checked against an in-order queue model of the reorder buffer.
module tb_rob_retire;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned IDXW  = 4;
  localparam int unsigned DW    = 32;

  logic                   clk = 1'b0;
  logic                   resetn;
  logic [1:0]             disp_valid;
  logic [1:0][4:0]        disp_dst;
  logic [1:0]             disp_regwrite;
  logic                   disp_ready;
  logic [1:0][IDXW-1:0]   disp_idx;
  logic [1:0]             wb_valid;
  logic [1:0][IDXW-1:0]   wb_idx;
  logic [1:0][DW-1:0]     wb_data;
  logic [1:0]             wb_exc;
  logic [1:0]             ret_valid;
  logic [1:0][4:0]        ret_dst;
  logic [1:0]             ret_regwrite;
  logic [1:0][DW-1:0]     ret_data;
  logic                   flush;
  logic [IDXW:0]          count;

  always #5 clk = ~clk;

  rob_retire #(.DEPTH(DEPTH), .IDXW(IDXW), .DWIDTH(DW)) dut (
    .clk(clk), .resetn(resetn),
    .i_disp_valid(disp_valid), .i_disp_dst(disp_dst), .i_disp_regwrite(disp_regwrite),
    .o_disp_ready(disp_ready), .o_disp_idx(disp_idx),
    .i_wb_valid(wb_valid), .i_wb_idx(wb_idx), .i_wb_data(wb_data), .i_wb_exc(wb_exc),
    .o_ret_valid(ret_valid), .o_ret_dst(ret_dst), .o_ret_regwrite(ret_regwrite),
    .o_ret_data(ret_data), .o_flush(flush), .o_count(count)
  );

  // Reference model: program-order queue of in-flight instructions
  typedef struct {
    logic [4:0]    dst;
    logic          rw;
    logic [DW-1:0] data;
    logic          done;
    logic          exc;
  } ent_t;

  ent_t q[$];
  int   m_head = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    disp_valid = '0; disp_dst = '0; disp_regwrite = '0;
    wb_valid = '0; wb_idx = '0; wb_data = '0; wb_exc = '0;
  endtask

  task automatic disp(input logic [1:0] v, input logic [4:0] d0, input logic [4:0] d1,
                      input logic [1:0] rw);
    disp_valid = v; disp_dst[0] = d0; disp_dst[1] = d1; disp_regwrite = rw;
  endtask

  task automatic wb(input logic [1:0] v, input int i0, input int i1,
                    input logic [DW-1:0] d0, input logic [DW-1:0] d1, input logic [1:0] e);
    wb_valid = v; wb_idx[0] = IDXW'(i0); wb_idx[1] = IDXW'(i1);
    wb_data[0] = d0; wb_data[1] = d1; wb_exc = e;
  endtask

  // Check outputs against the model, clock once, then advance the model
  task automatic step();
    int sz;
    int nret;
    int k;
    logic e_flush, e_ready, r0, r1;
    logic [1:0] acc;
    ent_t t;
    #1;
    sz      = q.size();
    e_flush = (sz > 0) && q[0].done && q[0].exc;
    r0      = (sz > 0) && q[0].done && !q[0].exc;
    r1      = r0 && (sz > 1) && q[1].done && !q[1].exc;
    e_ready = (sz <= DEPTH - 2);
    chk("count", 64'(count), 64'(sz));
    chk("disp_ready", 64'(disp_ready), 64'(e_ready));
    chk("flush", 64'(flush), 64'(e_flush));
    chk("ret_valid", 64'(ret_valid), 64'({r1, r0}));
    chk("ret_regwrite", 64'(ret_regwrite), 64'({r1 && q[1].rw, r0 && q[0].rw}));
    chk("disp_idx0", 64'(disp_idx[0]), 64'((m_head + sz) % DEPTH));
    chk("disp_idx1", 64'(disp_idx[1]), 64'((m_head + sz + int'(disp_valid[0])) % DEPTH));
    if (r0) begin
      chk("ret_dst0", 64'(ret_dst[0]), 64'(q[0].dst));
      chk("ret_data0", 64'(ret_data[0]), 64'(q[0].data));
    end
    if (r1) begin
      chk("ret_dst1", 64'(ret_dst[1]), 64'(q[1].dst));
      chk("ret_data1", 64'(ret_data[1]), 64'(q[1].data));
    end
    @(posedge clk);
    if (!resetn || e_flush) begin
      q.delete();
      m_head = 0;
    end else begin
      nret = r1 ? 2 : (r0 ? 1 : 0);
      acc  = disp_valid & {2{e_ready}};
      for (int p = 0; p < 2; p++) begin
        if (wb_valid[p]) begin
          k = (int'(wb_idx[p]) - m_head + DEPTH) % DEPTH;
          if (k < sz) begin
            t = q[k]; t.done = 1'b1; t.exc = wb_exc[p]; t.data = wb_data[p]; q[k] = t;
          end
        end
      end
      repeat (nret) void'(q.pop_front());
      m_head = (m_head + nret) % DEPTH;
      for (int l = 0; l < 2; l++) begin
        if (acc[l]) begin
          t.dst = disp_dst[l]; t.rw = disp_regwrite[l]; t.data = '0;
          t.done = 1'b0; t.exc = 1'b0;
          q.push_back(t);
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    idle();
    resetn = 1'b0;
    step();
    step();
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    idle();

    // Reset state
    do_reset();
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_ready", 64'(disp_ready), 64'(1));
    chk("rst_ret_valid", 64'(ret_valid), 64'(0));
    chk("rst_flush", 64'(flush), 64'(0));

    // Dual dispatch, dual writeback, dual retire
    disp(2'b11, 5'd3, 5'd4, 2'b11); step(); idle();
    wb(2'b11, 0, 1, 32'hAAAA0001, 32'hBBBB0002, 2'b00); step(); idle();
    chk("t1_ret_valid", 64'(ret_valid), 64'(2'b11));
    chk("t1_ret_dst", 64'(ret_dst), 64'({5'd4, 5'd3}));
    chk("t1_ret_data1", 64'(ret_data[1]), 64'(32'hBBBB0002));
    step();
    chk("t1_count", 64'(count), 64'(0));

    // Out-of-order completion
    do_reset();
    disp(2'b11, 5'd1, 5'd2, 2'b11); step();
    disp(2'b01, 5'd5, 5'd0, 2'b01); step(); idle();
    wb(2'b01, 2, 0, 32'h2222, 0, 2'b00); step(); idle();
    chk("t2_hold", 64'(ret_valid), 64'(0));
    wb(2'b01, 0, 0, 32'h0000, 0, 2'b00); step(); idle();
    chk("t2_single", 64'(ret_valid), 64'(2'b01));
    step();
    wb(2'b10, 0, 1, 0, 32'h1111, 2'b00); step(); idle();
    chk("t2_pair", 64'(ret_valid), 64'(2'b11));
    step();
    chk("t2_count", 64'(count), 64'(0));

    // Exception on head+1, flush the following cycle
    do_reset();
    disp(2'b11, 5'd7, 5'd8, 2'b10); step(); idle();
    wb(2'b11, 0, 1, 32'h5, 32'h6, 2'b10); step(); idle();
    chk("t3_rv", 64'(ret_valid), 64'(2'b01));
    chk("t3_noflush", 64'(flush), 64'(0));
    step();
    chk("t3_flush", 64'(flush), 64'(1));
    chk("t3_rv_flush", 64'(ret_valid), 64'(0));
    disp(2'b11, 5'd9, 5'd10, 2'b11); step(); idle();
    chk("t3_count", 64'(count), 64'(0));
    chk("t3_tail", 64'(disp_idx[0]), 64'(0));
    step();

    // Fill up, stall, drain two
    do_reset();
    repeat (7) begin disp(2'b11, 5'd1, 5'd2, 2'b11); step(); end
    chk("t4_count14", 64'(count), 64'(14));
    disp(2'b01, 5'd3, 5'd0, 2'b01); step();
    chk("t4_notready", 64'(disp_ready), 64'(0));
    disp(2'b11, 5'd4, 5'd5, 2'b11); step(); idle();
    chk("t4_dropped", 64'(count), 64'(15));
    wb(2'b11, 0, 1, 32'h10, 32'h11, 2'b00); step(); idle();
    step();
    chk("t4_ready", 64'(disp_ready), 64'(1));

    // Wrap: retire entries 15 and 0 together
    do_reset();
    repeat (7) begin disp(2'b11, 5'd6, 5'd7, 2'b01); step(); end
    disp(2'b01, 5'd8, 5'd0, 2'b01); step(); idle();
    for (int i = 0; i < 8; i++) begin
      wb((i == 7) ? 2'b01 : 2'b11, 2 * i, 2 * i + 1, DW'(100 + i), DW'(200 + i), 2'b00);
      step();
    end
    idle();
    repeat (3) step();
    chk("t5_empty", 64'(count), 64'(0));
    chk("t5_head15", 64'(disp_idx[0]), 64'(15));
    disp(2'b11, 5'd11, 5'd12, 2'b11); step(); idle();
    wb(2'b11, 15, 0, 32'hF00D, 32'hBEEF, 2'b00); step(); idle();
    chk("t5_wrap_rv", 64'(ret_valid), 64'(2'b11));
    chk("t5_wrap_data1", 64'(ret_data[1]), 64'(32'hBEEF));
    step();
    chk("t5_head1", 64'(disp_idx[0]), 64'(1));

    // Reset mid-operation discards in-flight work
    do_reset();
    disp(2'b11, 5'd1, 5'd2, 2'b11); step();
    disp(2'b11, 5'd3, 5'd4, 2'b11); step();
    disp(2'b01, 5'd5, 5'd0, 2'b01); step(); idle();
    wb(2'b11, 1, 3, 32'h1, 32'h3, 2'b00); step(); idle();
    chk("t6_count5", 64'(count), 64'(5));
    resetn = 1'b0;
    wb(2'b01, 0, 0, 32'h0, 0, 2'b00); step(); idle();
    resetn = 1'b1;
    chk("t6_count0", 64'(count), 64'(0));
    chk("t6_rv0", 64'(ret_valid), 64'(0));
    wb(2'b11, 0, 1, 32'h7, 32'h8, 2'b00); step(); idle();
    chk("t6_ignored", 64'(ret_valid), 64'(0));
    step();

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      int sz;
      idle();
      sz = q.size();
      disp($urandom_range(0, 3), 5'($urandom), 5'($urandom), 2'($urandom));
      for (int p = 0; p < 2; p++) begin
        if ($urandom_range(0, 2) != 0) begin
          wb_valid[p] = 1'b1;
          wb_idx[p]   = ($urandom_range(0, 7) == 0) ? IDXW'($urandom)
                                                    : IDXW'(m_head + $urandom_range(0, (sz > 0) ? sz - 1 : 0));
          wb_data[p]  = $urandom;
          wb_exc[p]   = ($urandom_range(0, 24) == 0);
        end
      end
      resetn = ($urandom_range(0, 299) != 0);
      step();
      resetn = 1'b1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
